// File: rtl/switch_accumulator.sv
// switch_accumulator_key: debounces one synchronised active-low key and fires a single event per clean press.
module switch_accumulator_key #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key,
  output logic fire,
  output logic active
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (!key) begin
        state_nx = ARMING;
        cnt_nx = ONE;
      end
      ARMING: if (key) begin
        state_nx = IDLE;
        cnt_nx = '0;
      end else if (cnt == LAST) begin
        state_nx = HELD;
        cnt_nx = '0;
      end else cnt_nx = cnt + ONE;
      HELD: if (key) begin
        state_nx = RELEASING;
        cnt_nx = ONE;
      end
      RELEASING: if (!key) begin
        state_nx = HELD;
        cnt_nx = '0;
      end else if (cnt == LAST) begin
        state_nx = IDLE;
        cnt_nx = '0;
      end else cnt_nx = cnt + ONE;
      default: begin
        state_nx = IDLE;
        cnt_nx = '0;
      end
    endcase
  end
  always_comb begin
    fire = state == ARMING && !key && cnt == LAST;
    active = state_nx != IDLE;
  end
endmodule

// switch_accumulator: debounced add/subtract of a switch word into a running LED total with sticky overflow.
module switch_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SATURATE = 0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] switch_export,
  input  logic              accumulate_export,
  input  logic              clear_export,
  input  logic              sub_mode_export,
  output logic [ACC_W-1:0]  led_wire_export,
  output logic              overflow_export,
  output logic              busy_export
);
  logic [DATA_W-1:0] sw_s1, sw_s2;
  logic sub_s1, sub_s2, acc_s1, acc_s2, clr_s1, clr_s2;
  logic acc_fire, acc_active, clr_fire, clr_active;
  logic [ACC_W-1:0] total, total_nx;
  logic [ACC_W:0] operand, sum, diff;
  logic ovf, busy, carry;
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      sub_s1 <= 1'b0;
      sub_s2 <= 1'b0;
      acc_s1 <= 1'b1;
      acc_s2 <= 1'b1;
      clr_s1 <= 1'b1;
      clr_s2 <= 1'b1;
    end else begin
      sw_s1 <= switch_export;
      sw_s2 <= sw_s1;
      sub_s1 <= sub_mode_export;
      sub_s2 <= sub_s1;
      acc_s1 <= accumulate_export;
      acc_s2 <= acc_s1;
      clr_s1 <= clear_export;
      clr_s2 <= clr_s1;
    end
  end
  switch_accumulator_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_acc_key (
    .clk(clk_clk), .reset_n(reset_reset_n), .key(acc_s2), .fire(acc_fire), .active(acc_active)
  );
  switch_accumulator_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_key (
    .clk(clk_clk), .reset_n(reset_reset_n), .key(clr_s2), .fire(clr_fire), .active(clr_active)
  );
  // Carry on add and borrow on subtract both show up in bit ACC_W of the extended result.
  always_comb begin
    operand = {{(ACC_W + 1 - DATA_W){1'b0}}, sw_s2};
    sum = {1'b0, total} + operand;
    diff = {1'b0, total} - operand;
    carry = sub_s2 ? diff[ACC_W] : sum[ACC_W];
    total_nx = (SATURATE != 0 && carry) ? (sub_s2 ? '0 : '1)
                                        : (sub_s2 ? diff[ACC_W-1:0] : sum[ACC_W-1:0]);
  end
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      total <= '0;
      ovf <= 1'b0;
      busy <= 1'b0;
    end else begin
      busy <= acc_active | clr_active;
      if (clr_fire) begin
        total <= '0;
        ovf <= 1'b0;
      end else if (acc_fire) begin
        total <= total_nx;
        ovf <= ovf | carry;
      end
    end
  end
  assign led_wire_export = total;
  assign overflow_export = ovf;
  assign busy_export = busy;
endmodule

// File: doc/switch_accumulator.md
# switch_accumulator

Parametrised accumulator peripheral that debounces active-low push-buttons, adds or subtracts a switch word into a running total on each clean press, and drives the total to the LED bank. It sits between the board switch/key pins and the LED pins, alongside the SoC, and replaces software polling of the accumulate and reset keys with dedicated hardware. It generalises the 8-bit accumulate/clear pair with configurable widths, debounce length, a wrap/saturate mode, a subtract mode and a sticky overflow flag.

## Interface
- DATA_W, 8: switch word width.
- ACC_W, 8: accumulator and LED width; must be ≥ DATA_W.
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples needed to accept a press or a release; must be ≥ 1.
- SATURATE, 0: 0 = wrap modulo 2^ACC_W; 1 = clamp at 2^ACC_W−1 (add) or 0 (subtract).
- clk_clk  in  1  single clock; all state on the rising edge.
- reset_reset_n  in  1  synchronous, active-low reset.
- switch_export  in  DATA_W  operand; asynchronous to clk_clk.
- accumulate_export  in  1  active-low key; asynchronous.
- clear_export  in  1  active-low key; asynchronous; clears total and flag.
- sub_mode_export  in  1  level; 1 = subtract operand; asynchronous.
- led_wire_export  out  ACC_W  current total (registered).
- overflow_export  out  1  sticky carry/borrow flag (registered).
- busy_export  out  1  high while either key FSM is outside IDLE.

## Operation
- switch_export, sub_mode_export, accumulate_export and clear_export each pass through a 2-flop synchroniser; only the second-stage values (s2) are used. Synchroniser flops reset to 0 for data and to 1 for keys (released).
- One FSM per key, identical, with states IDLE, ARMING, HELD, RELEASING:
  - IDLE: s2 = 0 → ARMING, cnt ← 1. Otherwise stay.
  - ARMING: s2 = 1 → IDLE, cnt ← 0 (chatter rejected). s2 = 0 and cnt = DEBOUNCE_CYCLES → HELD, fire a 1-cycle event. Otherwise cnt ← cnt+1.
  - HELD: s2 = 1 → RELEASING, cnt ← 1. No further events while held (no auto-repeat).
  - RELEASING: s2 = 0 → HELD, cnt ← 0. s2 = 1 and cnt = DEBOUNCE_CYCLES → IDLE. Otherwise cnt ← cnt+1.
  - cnt width is clog2(DEBOUNCE_CYCLES+1).
- Accumulate event: the operand is s2 of switch_export, zero-extended to ACC_W+1 bits, and the sum is formed at ACC_W+1 bits.
  - Add: when bit ACC_W of the sum is set, overflow ← 1; the total becomes the low ACC_W bits (SATURATE=0) or all-ones (SATURATE=1).
  - Subtract (s2 sub_mode = 1): when the operand exceeds the total, overflow ← 1; the total becomes (total − operand) mod 2^ACC_W (SATURATE=0) or 0 (SATURATE=1).
- Clear event: total ← 0, overflow ← 0.
- Clear and accumulate events in the same cycle: clear wins and the accumulate is discarded.
- overflow_export is set only by an event that carries or borrows, and is cleared only by clear or reset.
- Reset (any cycle, including mid-debounce or mid-hold): both FSMs go to IDLE, cnt = 0, total = 0, overflow = 0, busy = 0. A key still held low when reset releases must pass a full debounce before firing.

## Timing
- Reset values: led_wire_export = 0, overflow_export = 0, busy_export = 0.
- Press latency: if a key is first sampled low at edge k and stays low, the event fires in the cycle after edge k+1+DEBOUNCE_CYCLES. led_wire_export and overflow_export change at edge k+2+DEBOUNCE_CYCLES.
- busy_export is a registered copy of the "either FSM is not in IDLE" condition, so it lags state by 0 cycles. It rises at edge k+2.
- Operand and sub_mode are sampled at the event cycle (their s2 values). Switch changes less than 2 cycles before that cycle may or may not be used.
- Minimum key period is about 2×(DEBOUNCE_CYCLES+1) cycles; one physical press produces exactly one event.

## Test plan
- Reset, DEBOUNCE_CYCLES=4, ACC_W=8: switch=0x05, press accumulate 20 cycles, release 20 cycles → LED 0x05 exactly 6 cycles after the first low sample; press again → 0x0A; overflow stays 0.
- Chatter: accumulate low 3 cycles, high 1, low 3, then high → no event, LED unchanged, busy pulses then returns to 0.
- Wrap: SATURATE=0, total 0xF0, switch 0x20 → LED 0x10, overflow 1. The next add of 0x01 → 0x11 with overflow still 1. Clear → 0x00, overflow 0.
- Saturate: SATURATE=1, total 0xF0, add 0x20 → 0xFF, overflow 1. With sub_mode=1, subtract 0xFF then 0x01 → 0x00, then 0x00 with overflow still 1.
- Simultaneous: both keys pressed on the same cycle with total 0x33 → LED 0x00, overflow 0; releasing both produces no further change.
- Reset mid-operation: reset asserted during ARMING, and again during HELD with the key held through reset release → LED 0, busy 0, and exactly one event after a full DEBOUNCE_CYCLES post-reset.
